// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: lock/pin/software fault merge, 2^CNT_WIDTH hold, staggered channel release.
// Optional watchdog enabled by defining RST_SEQ_WDOG_EN.
module rst_sequencer #(
  parameter int CNT_WIDTH   = 24,
  parameter int NUM_LOCK    = 2,
  parameter int NUM_CHAN    = 3,
  parameter int STAGGER_CYC = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_WIDTH  = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LOCK-1:0] locked,
  input  logic                ext_rst_in_n,
  output logic                ext_rst_drive,
  input  logic                sw_rst_req,
  input  logic                wdog_kick,
  output logic [NUM_CHAN-1:0] chan_reset,
  output logic                all_ok,
  output logic [2:0]          cause
);

  localparam int STG_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  localparam logic [2:0] CAUSE_POR  = 3'd0;
  localparam logic [2:0] CAUSE_LOCK = 3'd1;
  localparam logic [2:0] CAUSE_EXT  = 3'd2;
  localparam logic [2:0] CAUSE_SW   = 3'd3;
  localparam logic [2:0] CAUSE_WDOG = 3'd4;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic [STG_W-1:0]                  stg_q, stg_d;
  logic [CH_W-1:0]                   chan_idx_q, chan_idx_d;
  logic [NUM_CHAN-1:0]               chan_reset_q, chan_reset_d;
  logic                              all_ok_q, all_ok_d;
  logic                              ext_rst_drive_q, ext_rst_drive_d;
  logic [2:0]                        cause_q, cause_d;
  logic [SYNC_STAGES-1:0][NUM_LOCK-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0]            ext_sync_q, ext_sync_d;

  logic       lock_ok, ext_ok, wdog_fault, hold_fault, fault;
  logic [2:0] fault_cause;

  assign lock_ok    = &lock_sync_q[SYNC_STAGES-1];
  assign ext_ok     = ext_sync_q[SYNC_STAGES-1];
  // Software requests only count once the sequence has left the hold phase.
  assign hold_fault = !lock_ok || !ext_ok;
  assign fault      = hold_fault || sw_rst_req || wdog_fault;

  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked};
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_in_n};
  end

  always_comb begin
    fault_cause = CAUSE_WDOG;
    if (!lock_ok)        fault_cause = CAUSE_LOCK;
    else if (!ext_ok)    fault_cause = CAUSE_EXT;
    else if (sw_rst_req) fault_cause = CAUSE_SW;
  end

`ifdef RST_SEQ_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (state_q == RUN && !wdog_kick) wdog_d = wdog_q + WDOG_WIDTH'(1);
  end

  assign wdog_fault = (state_q == RUN) && (wdog_q == '1) && !wdog_kick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  logic wdog_unused;
  assign wdog_unused = wdog_kick ^ (WDOG_WIDTH > 0);
  assign wdog_fault  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stg_d        = stg_q;
    chan_idx_d   = chan_idx_q;
    chan_reset_d = chan_reset_q;
    all_ok_d     = all_ok_q;
    cause_d      = cause_q;
    unique case (state_q)
      HOLD: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == '1 && !hold_fault) begin
          state_d    = STAGGER;
          stg_d      = '0;
          chan_idx_d = '0;
        end
      end
      STAGGER, RUN: begin
        if (fault) begin
          state_d      = HOLD;
          cnt_d        = '0;
          stg_d        = '0;
          chan_idx_d   = '0;
          chan_reset_d = '1;
          all_ok_d     = 1'b0;
          cause_d      = fault_cause;
        end else if (state_q == STAGGER) begin
          stg_d = stg_q + STG_W'(1);
          if (stg_q == STG_W'(STAGGER_CYC - 1)) begin
            stg_d      = '0;
            chan_idx_d = chan_idx_q + CH_W'(1);
            for (int k = 0; k < NUM_CHAN; k++) begin
              if (CH_W'(k) == chan_idx_q) chan_reset_d[k] = 1'b0;
            end
            if (chan_idx_q == CH_W'(NUM_CHAN - 1)) begin
              state_d  = RUN;
              all_ok_d = 1'b1;
            end
          end
        end
      end
      default: state_d = HOLD;
    endcase
    // Pin drive covers the first half of the hold so the pad can settle before terminal count.
    ext_rst_drive_d = (state_d == HOLD) && !cnt_d[CNT_WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= HOLD;
      cnt_q           <= '0;
      stg_q           <= '0;
      chan_idx_q      <= '0;
      chan_reset_q    <= '1;
      all_ok_q        <= 1'b0;
      ext_rst_drive_q <= 1'b1;
      cause_q         <= CAUSE_POR;
      lock_sync_q     <= '0;
      ext_sync_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stg_q           <= stg_d;
      chan_idx_q      <= chan_idx_d;
      chan_reset_q    <= chan_reset_d;
      all_ok_q        <= all_ok_d;
      ext_rst_drive_q <= ext_rst_drive_d;
      cause_q         <= cause_d;
      lock_sync_q     <= lock_sync_d;
      ext_sync_q      <= ext_sync_d;
    end
  end

  assign chan_reset    = chan_reset_q;
  assign all_ok        = all_ok_q;
  assign ext_rst_drive = ext_rst_drive_q;
  assign cause         = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with a small hold count; board pin is modelled as a pulled-up
// open-drain net looped back from ext_rst_drive.
module tb_rst_sequencer;

  logic       clk;
  logic       reset_n;
  logic [1:0] locked;
  logic       ext_rst_in_n;
  logic       ext_rst_drive;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic [2:0] chan_reset;
  logic       all_ok;
  logic [2:0] cause;
  logic       pin_n;

  int tests_run;
  int tests_failed;

  rst_sequencer #(
    .CNT_WIDTH  (4),
    .NUM_LOCK   (2),
    .NUM_CHAN   (3),
    .STAGGER_CYC(4),
    .SYNC_STAGES(2),
    .WDOG_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .ext_rst_in_n (ext_rst_in_n),
    .ext_rst_drive(ext_rst_drive),
    .sw_rst_req   (sw_rst_req),
    .wdog_kick    (wdog_kick),
    .chan_reset   (chan_reset),
    .all_ok       (all_ok),
    .cause        (cause)
  );

  assign ext_rst_in_n = ext_rst_drive ? 1'b0 : pin_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] exp_chan, input logic exp_ok,
                          input logic [2:0] exp_cause, input logic exp_drive);
    checkOutput({tag, "_chan"}, 32'(chan_reset), 32'(exp_chan));
    checkOutput({tag, "_ok"}, 32'(all_ok), 32'(exp_ok));
    checkOutput({tag, "_cause"}, 32'(cause), 32'(exp_cause));
    checkOutput({tag, "_drive"}, 32'(ext_rst_drive), 32'(exp_drive));
  endtask

  task automatic applyStimulus(input logic [1:0] lk, input logic pn, input logic sw, input logic kick);
    locked     = lk;
    pin_n      = pn;
    sw_rst_req = sw;
    wdog_kick  = kick;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered on the edge that moves HOLD to STAGGER; ends on the edge that enters RUN.
  task automatic staggerPart(input string tag, input logic [2:0] exp_cause);
    step(3);
    checkAll({tag, "_s3"}, 3'b111, 1'b0, exp_cause, 1'b0);
    step(1);
    checkOutput({tag, "_s4"}, 32'(chan_reset), 32'(3'b110));
    step(4);
    checkOutput({tag, "_s8"}, 32'(chan_reset), 32'(3'b100));
    step(3);
    checkOutput({tag, "_s11_ok"}, 32'(all_ok), 32'(1'b0));
    step(1);
    checkAll({tag, "_s12"}, 3'b000, 1'b1, exp_cause, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    step(3);
    checkAll("por", 3'b111, 1'b0, 3'd0, 1'b1);
    reset_n = 1'b1;

    step(7);
    checkOutput("por_drive_c7", 32'(ext_rst_drive), 32'(1'b1));
    step(1);
    checkOutput("por_drive_c8", 32'(ext_rst_drive), 32'(1'b0));
    step(8);
    staggerPart("por", 3'd0);

    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    step(2);
    checkOutput("lock_sync_wait", 32'(chan_reset), 32'(3'b000));
    step(1);
    checkAll("lock_fault", 3'b111, 1'b0, 3'd1, 1'b1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    step(16);
    staggerPart("relock", 3'd1);

    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    step(3);
    checkAll("hold_lock", 3'b111, 1'b0, 3'd1, 1'b1);
    step(8);
    checkOutput("hold_lock_c8", 32'(ext_rst_drive), 32'(1'b0));
    step(7);
    checkOutput("hold_lock_c15", 32'(ext_rst_drive), 32'(1'b0));
    step(1);
    checkAll("wrap", 3'b111, 1'b0, 3'd1, 1'b1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    step(4);
    checkOutput("no_stagger", 32'(chan_reset), 32'(3'b111));
    step(12);
    staggerPart("after_wrap", 3'd1);

    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
    step(2);
    checkOutput("ext_sync_wait", 32'(all_ok), 32'(1'b1));
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b0);
    step(1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    checkAll("ext_sw_prio", 3'b111, 1'b0, 3'd2, 1'b1);
    step(15);
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    step(1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    staggerPart("sw_in_hold", 3'd2);

    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
    step(1);
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
    checkAll("sw_fault", 3'b111, 1'b0, 3'd3, 1'b1);
    step(20);
    checkOutput("pre_async", 32'(chan_reset), 32'(3'b110));
    reset_n = 1'b0;
    #1;
    checkAll("async", 3'b111, 1'b0, 3'd0, 1'b1);
    step(1);
    reset_n = 1'b1;
    step(16);
    staggerPart("after_async", 3'd0);

    for (int i = 0; i < 4; i++) begin
      step(9);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
      step(1);
      applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
      checkOutput("wdog_kicked", 32'(all_ok), 32'(1'b1));
    end
    step(15);
    checkOutput("wdog_pre", 32'(all_ok), 32'(1'b1));
    step(1);
`ifdef RST_SEQ_WDOG_EN
    checkAll("wdog_fault", 3'b111, 1'b0, 3'd4, 1'b1);
`else
    checkAll("wdog_off", 3'b000, 1'b1, 3'd0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
